// File: rtl/ex_mul_div_unit_pkg.sv
// ex_mul_div_unit_pkg: op codes, FSM states and op-class predicates shared by the mul/div unit and its users.
package ex_mul_div_unit_pkg;

    typedef enum logic [2:0] {
        OPERATION_MULT  = 3'd0,
        OPERATION_MULTU = 3'd1,
        OPERATION_DIV   = 3'd2,
        OPERATION_DIVU  = 3'd3,
        OPERATION_MADD  = 3'd4,
        OPERATION_MADDU = 3'd5,
        OPERATION_MSUB  = 3'd6,
        OPERATION_MSUBU = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_CALC   = 2'd1,
        STATE_ADJUST = 2'd2,
        STATE_DONE   = 2'd3
    } state_t;

    // Even codes are the signed variants.
    function automatic logic is_signed(input operation_t op);
        return !op[0];
    endfunction

    function automatic logic is_divide(input operation_t op);
        return op[2:1] == 2'b01;
    endfunction

    function automatic logic is_accumulate(input operation_t op);
        return op[2];
    endfunction

    function automatic logic is_subtract(input operation_t op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/ex_mul_div_unit_if.sv
// ex_mul_div_unit_if: EX-stage request/result bundle for the iterative mul/div unit.
interface ex_mul_div_unit_if
    import ex_mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic             cancel;
    operation_t       operation;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] accumulate_hi;
    logic [WIDTH-1:0] accumulate_lo;
    logic             busy;
    logic             stall_request;
    logic             result_valid;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, cancel, operation, operand_a, operand_b, accumulate_hi, accumulate_lo,
        input  busy, stall_request, result_valid, result_hi, result_lo
    );

    modport slave (
        input  start, cancel, operation, operand_a, operand_b, accumulate_hi, accumulate_lo,
        output busy, stall_request, result_valid, result_hi, result_lo
    );
endinterface

// File: rtl/ex_mul_div_unit_mul_div_iterator.sv
// mul_div_iterator: one radix-2 step, either shift-add multiply or restoring divide, on a 2*WIDTH+1 work register.
module mul_div_iterator #(
    parameter int WIDTH = 32
) (
    input  logic             divide,
    input  logic [2*WIDTH:0] work,
    input  logic [WIDTH-1:0] operand,
    output logic [2*WIDTH:0] next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH:0] added;
    logic [2*WIDTH:0] shifted;

    // Multiply keeps the multiplier in the low half; divide keeps partial remainder high, quotient low.
    always_comb begin
        sum     = work[2*WIDTH:WIDTH] + (work[0] ? {1'b0, operand} : '0);
        added   = {sum, work[WIDTH-1:0]} >> 1;
        shifted = work << 1;
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
        next    = !divide ? added : diff[WIDTH] ? shifted : {diff, shifted[WIDTH-1:1], 1'b1};
    end
endmodule

// File: rtl/ex_mul_div_unit.sv
// ex_mul_div_unit: iterative multiply/divide/multiply-accumulate for EX, one bit per cycle,
// stalling the pipeline while busy and returning a 2*WIDTH hi/lo result.
module ex_mul_div_unit
    import ex_mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic              clock,
    input logic              reset,
    ex_mul_div_unit_if.slave bus
);
    localparam int COUNT_WIDTH = $clog2(WIDTH) + 1;
    localparam int W2 = 2 * WIDTH;

    state_t                 state_q, state_d;
    operation_t             op_q, op_d;
    logic                   neg_res_q, neg_res_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   dz_q, dz_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [W2:0]            work_q, work_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [W2-1:0]          acc_q, acc_d;
    logic [WIDTH-1:0]       res_hi_q, res_hi_d;
    logic [WIDTH-1:0]       res_lo_q, res_lo_d;

    logic             sign_a, sign_b, accept, div_zero;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [W2-1:0]    prod, accum, adjusted;
    logic [W2:0]      step;

    mul_div_iterator #(.WIDTH(WIDTH)) u_iterator (
        .divide (is_divide(op_q)),
        .work   (work_q),
        .operand(mcand_q),
        .next   (step)
    );

    always_comb begin
        accept   = state_q == STATE_IDLE && bus.start && !bus.cancel;
        sign_a   = is_signed(bus.operation) & bus.operand_a[WIDTH-1];
        sign_b   = is_signed(bus.operation) & bus.operand_b[WIDTH-1];
        mag_a    = sign_a ? -bus.operand_a : bus.operand_a;
        mag_b    = sign_b ? -bus.operand_b : bus.operand_b;
        div_zero = is_divide(bus.operation) && bus.operand_b == '0;
        prod     = neg_res_q ? -work_q[W2-1:0] : work_q[W2-1:0];
        quo      = neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        rem      = neg_rem_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];
        accum    = is_subtract(op_q) ? acc_q - prod : acc_q + prod;
        // Divide-by-zero pre-loads its final {operand_a, all ones} image into the work register.
        adjusted = dz_q ? work_q[W2-1:0] : is_divide(op_q) ? {rem, quo} : is_accumulate(op_q) ? accum : prod;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        count_d   = count_q;
        work_d    = work_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        unique case (state_q)
            STATE_IDLE: if (accept) begin
                op_d      = bus.operation;
                neg_res_d = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                dz_d      = div_zero;
                count_d   = '0;
                mcand_d   = is_divide(bus.operation) ? mag_b : mag_a;
                acc_d     = {bus.accumulate_hi, bus.accumulate_lo};
                work_d    = div_zero ? {1'b0, bus.operand_a, {WIDTH{1'b1}}}
                                     : {{(WIDTH+1){1'b0}}, is_divide(bus.operation) ? mag_a : mag_b};
                state_d   = div_zero ? STATE_ADJUST : STATE_CALC;
            end
            STATE_CALC: begin
                work_d  = step;
                count_d = count_q + 1'b1;
                state_d = count_q == COUNT_WIDTH'(WIDTH - 1) ? STATE_ADJUST : STATE_CALC;
            end
            STATE_ADJUST: begin
                {res_hi_d, res_lo_d} = bus.cancel ? {res_hi_q, res_lo_q} : adjusted;
                state_d              = STATE_DONE;
            end
            STATE_DONE: state_d = STATE_IDLE;
        endcase
        if (bus.cancel) state_d = STATE_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= STATE_IDLE;
            op_q      <= OPERATION_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            count_q   <= '0;
            work_q    <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            count_q   <= count_d;
            work_q    <= work_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
        end
    end

    // Reset gates the stall so a start held through reset cannot hold the pipeline.
    assign bus.stall_request = !reset && (accept || state_q == STATE_CALC || state_q == STATE_ADJUST);
    assign bus.busy          = state_q != STATE_IDLE;
    assign bus.result_valid  = state_q == STATE_DONE && !bus.cancel;
    assign bus.result_hi     = res_hi_q;
    assign bus.result_lo     = res_lo_q;
endmodule

// File: doc/ex_mul_div_unit.md
Name: ex_mul_div_unit

Overview:
- Parametrised, iterative multiply/divide/multiply-accumulate unit for the execute stage.
- Replaces single-cycle combinational HI/LO arithmetic with a radix-2 sequential datapath (one bit per cycle) and adds DIV/DIVU and MADD/MADDU/MSUB/MSUBU.
- Holds the pipeline through stall_request while busy.
- Returns a 2*WIDTH result split into hi/lo for the stage's HI/LO write path.

Parameters:
WIDTH, 32, operand width and hi/lo width; even and >= 4
COUNT_WIDTH, $clog2(WIDTH)+1, iteration counter width; derived, not overridden

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  EX holds a mul/div op; held high by EX until result_valid
cancel  input  1  pipeline flush; aborts any operation
operation  input  3  op code (shared package encoding)
operand_a  input  WIDTH  multiplicand / dividend
operand_b  input  WIDTH  multiplier / divisor
accumulate_hi  input  WIDTH  newest forwarded HI (MADD/MSUB source)
accumulate_lo  input  WIDTH  newest forwarded LO
busy  output  1  state is not IDLE
stall_request  output  1  pipeline hold request
result_valid  output  1  one-cycle pulse; result_hi/lo valid
result_hi  output  WIDTH  product high half / remainder
result_lo  output  WIDTH  product low half / quotient

Behaviour:
- Reset (async, active-high): state IDLE; busy, stall_request, result_valid = 0; result_hi, result_lo, counter and internal registers = 0. Reset mid-operation discards the operation.
- States:
  - IDLE: start & !cancel latches operands and op, then goes to CALC. Divide op with operand_b==0 goes to ADJUST instead.
  - CALC: counter runs WIDTH cycles, then goes to ADJUST.
  - ADJUST: sign fix and accumulate; next state DONE.
  - DONE: result_valid=1 for exactly one cycle; next state IDLE.
- Signed ops:
  - Operands are converted to magnitudes at latch time.
  - Multiply result is negated when sign_a ^ sign_b.
  - Quotient is negated when sign_a ^ sign_b.
  - Remainder takes the sign of the dividend.
- Multiply: shift-add, one multiplier bit per CALC cycle, 2*WIDTH product register.
- Divide: restoring, one quotient bit per CALC cycle. Quotient goes to result_lo, remainder to result_hi.
- Accumulate ops: {accumulate_hi, accumulate_lo} are sampled at latch time. ADJUST forms acc + product (MADD/MADDU) or acc - product (MSUB/MSUBU), modulo 2^(2*WIDTH).
- Latency:
  - Start accepted in cycle 0; result_valid in cycle WIDTH+2.
  - Divide-by-zero: result_valid in cycle 2.
- stall_request:
  - Combinational: (IDLE & start & !cancel) | CALC | ADJUST.
  - Low in DONE, so EX advances in the result_valid cycle.
  - start seen in DONE is ignored; it is the same instruction.
- Divide by zero (both signednesses): result_hi = operand_a unmodified; result_lo = all ones.
- Signed overflow: most-negative / -1 gives result_lo = most-negative, result_hi = 0, no trap.
- cancel:
  - Priority over start.
  - In any state, forces IDLE next cycle.
  - Suppresses result_valid, including when asserted in DONE (result_valid gated combinationally by !cancel).
  - A new start is accepted in the cycle after cancel deasserts.
- result_hi/lo hold their last value until the next DONE; consumers use them only on result_valid.
- Widths: all internal arithmetic is 2*WIDTH+1 bits; carries beyond 2*WIDTH are dropped.

Decomposition:
- Shared package / header holds:
  - OPERATION_MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7.
  - State encoding IDLE/CALC/ADJUST/DONE.
  - Helper predicates is_signed, is_divide, is_accumulate.
- One natural sub-module: mul_div_iterator, the per-cycle shift-add / restoring-subtract datapath step. It is instantiated once; the FSM, sign handling and accumulate stay in the top.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 -> result_valid at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_request high in cycles 0-33, low at 34.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 5/0 -> result_valid at cycle 2; hi=5, lo=0xFFFFFFFF. DIVU 0xFFFFFFFF/0 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- MADDU acc={0,0xFFFFFFFF}, 1*1 -> hi=1, lo=0. MSUB acc={0,0}, 2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- start MULTU then cancel at CALC cycle 10 -> IDLE next cycle, no result_valid, busy=0. Start MULTU 3*4 next cycle -> lo=12 at +34.
- Assert reset at CALC cycle 5 -> busy, stall_request, result_valid and result_hi/lo all 0 without a clock edge. Start held through reset release -> operation restarts and completes normally.
